// File: rtl/math_pkg.sv
// Shared math-library definitions: divider state encoding and Q2.(WDTH-2) format helpers.
package math_pkg;

  localparam int unsigned DIV_STATE_W = 2;

  localparam logic [DIV_STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [DIV_STATE_W-1:0] ST_CALC = 2'd1;
  localparam logic [DIV_STATE_W-1:0] ST_DONE = 2'd2;

  // Fractional bits of the Q2.(w-2) format; 1.0 = 2^(w-2).
  function automatic int unsigned q_frac_bits(input int unsigned w);
    return w - 2;
  endfunction

  // Width of the pre-scaled numerator |x| << (w-2).
  function automatic int unsigned q_num_bits(input int unsigned w);
    return 2 * w - 2;
  endfunction

  // Largest positive result, 2^(w-1)-1.
  function automatic logic [63:0] q_sat_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Magnitude of the most negative result, 2^(w-1).
  function automatic logic [63:0] q_sat_neg_mag(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/divide_step.sv
// One restoring shift-subtract iteration on magnitudes.
module divide_step #(
  parameter int unsigned WDTH = 18
) (
  input  logic [WDTH-1:0] rem,
  input  logic            num_bit,
  input  logic [WDTH-1:0] den,
  output logic [WDTH-1:0] rem_next,
  output logic            q_bit
);

  logic [WDTH:0] shifted;

  // Remainder stays below den, so both branches fit back into WDTH bits.
  always_comb begin
    shifted  = {rem, num_bit};
    q_bit    = (shifted >= {1'b0, den});
    rem_next = q_bit ? WDTH'(shifted - {1'b0, den}) : WDTH'(shifted);
  end

endmodule

// File: rtl/divide.sv
// Iterative signed Q2.(WDTH-2) divider z = x / y, one quotient bit per clock.
// Optional ovf flag output enabled by defining DIVIDE_OVF_EN.
module divide #(
  parameter int unsigned WDTH = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WDTH-1:0] x,
  input  logic [WDTH-1:0] y,
  output logic            out_valid,
`ifdef DIVIDE_OVF_EN
  output logic            ovf,
`endif
  output logic [WDTH-1:0] z
);
  import math_pkg::*;

  localparam int unsigned NW = q_num_bits(WDTH);
  localparam int unsigned FW = q_frac_bits(WDTH);
  localparam int unsigned CW = $clog2(NW + 1);

  localparam logic [NW-1:0]   LIM_POS = NW'(q_sat_pos(WDTH));
  localparam logic [NW-1:0]   LIM_NEG = NW'(q_sat_neg_mag(WDTH));
  localparam logic [WDTH-1:0] Z_POS   = WDTH'(q_sat_pos(WDTH));
  localparam logic [WDTH-1:0] Z_NEG   = WDTH'(q_sat_neg_mag(WDTH));

  logic [DIV_STATE_W-1:0] state_q, state_nxt;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic [WDTH-1:0]        rem_q, rem_nxt;
  logic [NW-1:0]          num_q, num_nxt;
  logic [NW-2:0]          quo_q, quo_nxt;
  logic [WDTH-1:0]        den_q, den_nxt;
  logic                   neg_q, neg_nxt;
  logic                   xz_q, xz_nxt;
  logic                   in_ready_nxt, out_valid_nxt;
  logic [WDTH-1:0]        z_nxt;

  logic [WDTH-1:0]        ax, ay;
  logic [WDTH-1:0]        step_rem;
  logic                   step_q;
  logic [NW-1:0]          quo_fin;
  logic [NW-1:0]          lim;
  logic                   sat;
  logic [WDTH-1:0]        res;

`ifdef DIVIDE_OVF_EN
  logic                   yz_q, yz_nxt;
  logic                   ovf_nxt;
`endif

  divide_step #(.WDTH(WDTH)) u_step (
    .rem      (rem_q),
    .num_bit  (num_q[NW-1]),
    .den      (den_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Magnitudes; |-2^(WDTH-1)| = 2^(WDTH-1) is kept as an unsigned WDTH-bit value.
  always_comb begin
    ax = x[WDTH-1] ? WDTH'(-x) : x;
    ay = y[WDTH-1] ? WDTH'(-y) : y;
  end

  // Final quotient, sign application and saturation; valid on the last CALC cycle.
  always_comb begin
    quo_fin = {quo_q, step_q};
    lim     = neg_q ? LIM_NEG : LIM_POS;
    sat     = (quo_fin > lim);
    if (xz_q) begin
      res = '0;
    end else if (sat) begin
      res = neg_q ? Z_NEG : Z_POS;
    end else begin
      res = neg_q ? WDTH'(-quo_fin[WDTH-1:0]) : quo_fin[WDTH-1:0];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    rem_nxt   = rem_q;
    num_nxt   = num_q;
    quo_nxt   = quo_q;
    den_nxt   = den_q;
    neg_nxt   = neg_q;
    xz_nxt    = xz_q;
    z_nxt     = z;
`ifdef DIVIDE_OVF_EN
    yz_nxt    = yz_q;
    ovf_nxt   = ovf;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt = ST_CALC;
          cnt_nxt   = CW'(NW);
          rem_nxt   = '0;
          num_nxt   = {ax, {FW{1'b0}}};
          quo_nxt   = '0;
          den_nxt   = ay;
          neg_nxt   = x[WDTH-1] ^ y[WDTH-1];
          xz_nxt    = (x == '0);
`ifdef DIVIDE_OVF_EN
          yz_nxt    = (y == '0);
`endif
        end
      end
      ST_CALC: begin
        cnt_nxt = cnt_q - CW'(1);
        rem_nxt = step_rem;
        num_nxt = {num_q[NW-2:0], 1'b0};
        quo_nxt = quo_fin[NW-2:0];
        if (cnt_q == CW'(1)) begin
          state_nxt = ST_DONE;
          z_nxt     = res;
`ifdef DIVIDE_OVF_EN
          ovf_nxt   = yz_q | sat;
`endif
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    in_ready_nxt  = (state_nxt == ST_IDLE);
    out_valid_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      num_q     <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      neg_q     <= 1'b0;
      xz_q      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      z         <= '0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      rem_q     <= rem_nxt;
      num_q     <= num_nxt;
      quo_q     <= quo_nxt;
      den_q     <= den_nxt;
      neg_q     <= neg_nxt;
      xz_q      <= xz_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      z         <= z_nxt;
    end
  end

`ifdef DIVIDE_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      yz_q <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      yz_q <= yz_nxt;
      ovf  <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_divide.sv
// Directed self-checking bench for divide at WDTH=8 (1.0 = 64).
module tb_divide;

  localparam int unsigned WDTH = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [WDTH-1:0] x;
  logic [WDTH-1:0] y;
  logic            out_valid;
  logic [WDTH-1:0] z;
`ifdef DIVIDE_OVF_EN
  logic            ovf;
`endif

  int total = 0;
  int bad   = 0;
  int ovf_skipped = 0;

  divide #(.WDTH(WDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
`ifdef DIVIDE_OVF_EN
    .ovf       (ovf),
`endif
    .z         (z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One division: drive operands, confirm latency, busy window, result and return to idle.
  task automatic run_div(input string tag, input int xi, input int yi, input int zi, input bit ovfi);
    logic [WDTH-1:0] ez;
    int  lat;
    bit  busy_ok;
    ez = WDTH'(zi);
    @(negedge clk);
    x = WDTH'(xi);
    y = WDTH'(yi);
    in_valid = 1'b1;
    chk({tag, ":ready_before"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    x = 8'h5a;
    y = 8'h11;
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready !== 1'b0) busy_ok = 1'b0;
    chk({tag, ":latency"}, 32'(lat), 32'd15);
    chk({tag, ":busy_not_ready"}, 32'(busy_ok), 32'd1);
    chk({tag, ":z"}, 32'(z), 32'(ez));
`ifdef DIVIDE_OVF_EN
    chk({tag, ":ovf"}, 32'(ovf), 32'(ovfi));
`else
    ovf_skipped += int'(ovfi);
`endif
    @(negedge clk);
    chk({tag, ":valid_pulse"}, 32'(out_valid), 32'd0);
    chk({tag, ":ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int  nres;
    int  nacc;
    bit  ov_seen;

    // Reset held together with in_valid: nothing may be accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    x = 8'd5;
    y = 8'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("reset:in_ready", 32'(in_ready), 32'd1);
    chk("reset:out_valid", 32'(out_valid), 32'd0);
    chk("reset:z", 32'(z), 32'd0);
`ifdef DIVIDE_OVF_EN
    chk("reset:ovf", 32'(ovf), 32'd0);
`endif
    ov_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    chk("reset:no_spurious_result", 32'(ov_seen), 32'd0);

    run_div("half",      32,   64,   32,  1'b0);
    run_div("trunc",    -16,   48,  -21,  1'b0);
    run_div("negneg",  -128, -128,   64,  1'b0);
    run_div("exactmin",-128,   64, -128,  1'b0);
    run_div("satpos",    64,   32,  127,  1'b1);
    run_div("satneg",   -64,   16, -128,  1'b1);
    run_div("dz_pos",     5,    0,  127,  1'b1);
    run_div("dz_neg",    -5,    0, -128,  1'b1);
    run_div("dz_zero",    0,    0,    0,  1'b1);

    // Continuous in_valid with operands changing every cycle; y = 1.0 so z = accepted x.
    @(negedge clk);
    nres = 0;
    nacc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      x = WDTH'(c + 1);
      y = 8'd64;
      if (out_valid === 1'b1) begin
        chk("thru:z", 32'(z), 32'(16 * nres + 1));
        chk("thru:cycle", 32'(c), 32'(16 * nres + 15));
        nres++;
      end
      if (in_ready === 1'b1) nacc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("thru:results", 32'(nres), 32'd4);
    chk("thru:accepts", 32'(nacc), 32'd4);
    repeat (20) @(negedge clk);

    // Reset in cycle 7 of a division aborts it silently.
    x = 8'd32;
    y = 8'd64;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ov_seen = 1'b0;
    for (int c = 1; c < 7; c++) begin
      if (out_valid !== 1'b0) ov_seen = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort:in_ready", 32'(in_ready), 32'd1);
    chk("abort:z", 32'(z), 32'd0);
    chk("abort:out_valid", 32'(out_valid), 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    chk("abort:no_result", 32'(ov_seen), 32'd0);
    run_div("after_abort", 32, 64, 32, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
